// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - shared widths, opcode encoding and staging record
// Contents: REG_W, NUM_REGS, SEL_W, alu_op_e opcode enum, stage_t staging record.
package alu_operand_stage_pkg;

    localparam int REG_W    = 16;
    localparam int NUM_REGS = 8;
    localparam int SEL_W    = 3;

    // 000-011 are the shift/rotate group, 1xx the arithmetic/logic group.
    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ADD = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_AND = 3'b111
    } alu_op_e;

    // Everything the stage holds for one instruction, cleared as a unit.
    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] a;
        logic [REG_W-1:0] b;
        alu_op_e          op;
        logic             cin;
        logic             inva;
        logic             invb;
        logic             sign;
    } stage_t;

endpackage

// File: rtl/rf_bypass.sv
// rtl/rf_bypass.sv - 8x16 register file with one write port and two bypassed read ports
// Ports:
//   clk, rst                  clock, synchronous active-high reset (clears all registers)
//   wr_en, wr_sel, wr_data    write port, committed on the rising edge
//   rd_sel1, rd_sel2          read selects
//   rd_data1, rd_data2        combinational read data, forwarding same-cycle write data
module rf_bypass
    import alu_operand_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [REG_W-1:0] wr_data,
    input  logic [SEL_W-1:0] rd_sel1,
    input  logic [SEL_W-1:0] rd_sel2,
    output logic [REG_W-1:0] rd_data1,
    output logic [REG_W-1:0] rd_data2
);

    logic [REG_W-1:0] regs [NUM_REGS];

    // All eight entries are general purpose; there is no hardwired zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_sel] <= wr_data;
        end
    end

    // A write in the same cycle wins over the stored value so the stage
    // captures the value the register will hold after this edge.
    assign rd_data1 = (wr_en && (wr_sel == rd_sel1)) ? wr_data : regs[rd_sel1];
    assign rd_data2 = (wr_en && (wr_sel == rd_sel2)) ? wr_data : regs[rd_sel2];

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - register-file read, B-operand select and ALU operand staging register
// Ports:
//   clk, rst                               clock, synchronous active-high reset
//   wr_en, wr_sel, wr_data                 register-file write port
//   in_valid, rd_sel1, rd_sel2, imm,
//   use_imm, op_in, cin_in, inva_in,
//   invb_in, sign_in                       upstream instruction fields
//   stall, flush                           downstream hold / kill controls
//   A, B, Op, Cin, invA, invB, sign        registered ALU operands and controls
//   out_valid                              staged contents valid
module alu_operand_stage
    import alu_operand_stage_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_sel,
    input  logic [REG_W-1:0] wr_data,
    input  logic             in_valid,
    input  logic [SEL_W-1:0] rd_sel1,
    input  logic [SEL_W-1:0] rd_sel2,
    input  logic [REG_W-1:0] imm,
    input  logic             use_imm,
    input  logic [2:0]       op_in,
    input  logic             cin_in,
    input  logic             inva_in,
    input  logic             invb_in,
    input  logic             sign_in,
    input  logic             stall,
    input  logic             flush,
    output logic [REG_W-1:0] A,
    output logic [REG_W-1:0] B,
    output logic [2:0]       Op,
    output logic             Cin,
    output logic             invA,
    output logic             invB,
    output logic             sign,
    output logic             out_valid
);

    logic [REG_W-1:0] rd_data1;
    logic [REG_W-1:0] rd_data2;
    stage_t           stage_d;
    stage_t           stage_q;

    rf_bypass u_rf (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .rd_sel1  (rd_sel1),
        .rd_sel2  (rd_sel2),
        .rd_data1 (rd_data1),
        .rd_data2 (rd_data2)
    );

    // Data fields load even when in_valid is low; consumers qualify with out_valid.
    always_comb begin
        stage_d       = '0;
        stage_d.valid = in_valid;
        stage_d.a     = rd_data1;
        stage_d.b     = use_imm ? imm : rd_data2;
        stage_d.op    = alu_op_e'(op_in);
        stage_d.cin   = cin_in;
        stage_d.inva  = inva_in;
        stage_d.invb  = invb_in;
        stage_d.sign  = sign_in;
    end

    // Priority: reset, then flush (overrides stall), then stall holds, else capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= '0;
        end else if (flush) begin
            stage_q <= '0;
        end else if (!stall) begin
            stage_q <= stage_d;
        end
    end

    assign out_valid = stage_q.valid;
    assign A         = stage_q.a;
    assign B         = stage_q.b;
    assign Op        = stage_q.op;
    assign Cin       = stage_q.cin;
    assign invA      = stage_q.inva;
    assign invB      = stage_q.invb;
    assign sign      = stage_q.sign;

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - self-checking bench for alu_operand_stage
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [15:0] wr_data;
    logic        in_valid;
    logic [2:0]  rd_sel1;
    logic [2:0]  rd_sel2;
    logic [15:0] imm;
    logic        use_imm;
    logic [2:0]  op_in;
    logic        cin_in;
    logic        inva_in;
    logic        invb_in;
    logic        sign_in;
    logic        stall;
    logic        flush;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  Op;
    logic        Cin;
    logic        invA;
    logic        invB;
    logic        sign;
    logic        out_valid;

    int checks   = 0;
    int failures = 0;

    // Reference model: architectural register contents and expected outputs.
    logic [15:0] m_regs [8];
    logic        m_valid;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [2:0]  m_op;
    logic        m_cin;
    logic        m_inva;
    logic        m_invb;
    logic        m_sign;

    logic [39:0] obs;
    assign obs = {out_valid, A, B, Op, Cin, invA, invB, sign};

    always #5 clk = ~clk;

    alu_operand_stage dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data),
        .in_valid  (in_valid),
        .rd_sel1   (rd_sel1),
        .rd_sel2   (rd_sel2),
        .imm       (imm),
        .use_imm   (use_imm),
        .op_in     (op_in),
        .cin_in    (cin_in),
        .inva_in   (inva_in),
        .invb_in   (invb_in),
        .sign_in   (sign_in),
        .stall     (stall),
        .flush     (flush),
        .A         (A),
        .B         (B),
        .Op        (Op),
        .Cin       (Cin),
        .invA      (invA),
        .invB      (invB),
        .sign      (sign),
        .out_valid (out_valid)
    );

    function automatic logic [39:0] exp_vec();
        return {m_valid, m_a, m_b, m_op, m_cin, m_inva, m_invb, m_sign};
    endfunction

    function automatic logic [15:0] model_read(input logic [2:0] sel);
        if (wr_en && wr_sel == sel) return wr_data;
        return m_regs[sel];
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    function automatic void model_step();
        logic [15:0] ra;
        logic [15:0] rb;
        if (rst) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
            {m_valid, m_a, m_b, m_op, m_cin, m_inva, m_invb, m_sign} = '0;
            return;
        end
        ra = model_read(rd_sel1);
        rb = use_imm ? imm : model_read(rd_sel2);
        if (wr_en) m_regs[wr_sel] = wr_data;
        if (flush) begin
            {m_valid, m_a, m_b, m_op, m_cin, m_inva, m_invb, m_sign} = '0;
        end else if (!stall) begin
            m_valid = in_valid;
            m_a     = ra;
            m_b     = rb;
            m_op    = op_in;
            m_cin   = cin_in;
            m_inva  = inva_in;
            m_invb  = invb_in;
            m_sign  = sign_in;
        end
    endfunction

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; wr_en = 1'b0; wr_sel = 3'd0; wr_data = 16'h0;
        in_valid = 1'b0; rd_sel1 = 3'd0; rd_sel2 = 3'd0; imm = 16'h0;
        use_imm = 1'b0; op_in = 3'd0; cin_in = 1'b0; inva_in = 1'b0;
        invb_in = 1'b0; sign_in = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'hABCD; in_valid = 1'b1;
        step();
        checks++;
        if (obs !== 40'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h", obs, 40'd0);
        end
        idle();
    endtask

    task automatic test_zero_read();
        idle();
        rd_sel1 = 3'd3; rd_sel2 = 3'd5; in_valid = 1'b1;
        step();
        checks++;
        if (A !== 16'h0000 || B !== 16'h0000 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL zero_read got A=%h B=%h v=%b want A=0000 B=0000 v=1", A, B, out_valid);
        end
        checks++;
        if (obs !== exp_vec()) begin
            failures++;
            $display("FAIL zero_read_all got=%h want=%h", obs, exp_vec());
        end
    endtask

    task automatic test_write_read();
        idle();
        wr_en = 1'b1; wr_sel = 3'd2; wr_data = 16'h1234;
        step();
        idle();
        rd_sel1 = 3'd2; op_in = 3'b100; in_valid = 1'b1;
        step();
        checks++;
        if (A !== 16'h1234 || Op !== 3'b100) begin
            failures++;
            $display("FAIL write_read got A=%h Op=%b want A=1234 Op=100", A, Op);
        end
    endtask

    task automatic test_bypass();
        idle();
        wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'hBEEF;
        rd_sel1 = 3'd4; rd_sel2 = 3'd4; in_valid = 1'b1;
        step();
        checks++;
        if (A !== 16'hBEEF || B !== 16'hBEEF) begin
            failures++;
            $display("FAIL bypass got A=%h B=%h want BEEF BEEF", A, B);
        end
    endtask

    task automatic test_imm();
        idle();
        wr_en = 1'b1; wr_sel = 3'd5; wr_data = 16'hAAAA;
        step();
        idle();
        rd_sel2 = 3'd5; use_imm = 1'b1; imm = 16'h00F0; in_valid = 1'b1;
        step();
        checks++;
        if (B !== 16'h00F0) begin
            failures++;
            $display("FAIL imm_select got B=%h want 00F0", B);
        end
    endtask

    task automatic test_in_valid_low();
        idle();
        wr_en = 1'b1; wr_sel = 3'd6; wr_data = 16'h6060;
        step();
        idle();
        rd_sel1 = 3'd6; op_in = 3'b111; sign_in = 1'b1; in_valid = 1'b0;
        step();
        checks++;
        if (A !== 16'h6060 || Op !== 3'b111 || sign !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL invalid_capture got A=%h Op=%b s=%b v=%b want 6060 111 1 0", A, Op, sign, out_valid);
        end
    endtask

    task automatic test_stall_flush();
        logic [39:0] snap;
        idle();
        wr_en = 1'b1; wr_sel = 3'd1; wr_data = 16'h1111;
        rd_sel1 = 3'd1; in_valid = 1'b1; op_in = 3'b110; cin_in = 1'b1; inva_in = 1'b1;
        step();
        checks++;
        if (A !== 16'h1111 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL stall_setup got A=%h v=%b want 1111 1", A, out_valid);
        end
        snap = obs;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'($urandom_range(0, 1)); wr_sel = 3'($urandom); wr_data = 16'($urandom);
            rd_sel1 = 3'($urandom); rd_sel2 = 3'($urandom); imm = 16'($urandom);
            use_imm = 1'($urandom); op_in = 3'($urandom); in_valid = 1'($urandom);
            cin_in = 1'($urandom); inva_in = 1'($urandom); invb_in = 1'($urandom);
            sign_in = 1'($urandom); stall = 1'b1; flush = 1'b0;
            step();
            checks++;
            if (obs !== snap || obs !== exp_vec()) begin
                failures++;
                $display("FAIL stall_hold cyc=%0d got=%h want=%h", i, obs, snap);
            end
        end
        idle();
        stall = 1'b1; flush = 1'b1; rd_sel1 = 3'd1; in_valid = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || A !== 16'h0000 || obs !== 40'd0) begin
            failures++;
            $display("FAIL flush_over_stall got=%h want=%h", obs, 40'd0);
        end
    endtask

    task automatic test_reset_priority();
        idle();
        wr_en = 1'b1; wr_sel = 3'd7; wr_data = 16'hFFFF;
        step();
        idle();
        rd_sel1 = 3'd7; in_valid = 1'b1;
        step();
        checks++;
        if (A !== 16'hFFFF) begin
            failures++;
            $display("FAIL r7_written got A=%h want FFFF", A);
        end
        idle();
        rst = 1'b1; wr_en = 1'b1; wr_sel = 3'd7; wr_data = 16'h5555; stall = 1'b1; in_valid = 1'b1;
        step();
        checks++;
        if (obs !== 40'd0) begin
            failures++;
            $display("FAIL reset_priority got=%h want=%h", obs, 40'd0);
        end
        idle();
        rd_sel1 = 3'd7; rd_sel2 = 3'd7; in_valid = 1'b1;
        step();
        checks++;
        if (A !== 16'h0000 || B !== 16'h0000 || out_valid !== 1'b1) begin
            failures++;
            $display("FAIL r7_after_reset got A=%h B=%h v=%b want 0000 0000 1", A, B, out_valid);
        end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 31) == 0);
            wr_en    = 1'($urandom);
            wr_sel   = 3'($urandom);
            wr_data  = 16'($urandom);
            in_valid = 1'($urandom);
            rd_sel1  = 3'($urandom);
            rd_sel2  = ($urandom_range(0, 3) == 0) ? wr_sel : 3'($urandom);
            imm      = 16'($urandom);
            use_imm  = 1'($urandom);
            op_in    = 3'($urandom);
            cin_in   = 1'($urandom);
            inva_in  = 1'($urandom);
            invb_in  = 1'($urandom);
            sign_in  = 1'($urandom);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            step();
            checks++;
            if (obs !== exp_vec()) begin
                failures++;
                bad++;
                if (bad <= 10) $display("FAIL random cyc=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
        {m_valid, m_a, m_b, m_op, m_cin, m_inva, m_invb, m_sign} = '0;
        test_reset();
        test_zero_read();
        test_write_read();
        test_bypass();
        test_imm();
        test_in_valid_low();
        test_stall_flush();
        test_reset_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The module SHALL have the following ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  register-file write enable.
- wr_sel  in  3  write register index.
- wr_data  in  16  write data.
- in_valid  in  1  upstream instruction valid.
- rd_sel1  in  3  source register for A.
- rd_sel2  in  3  source register for B.
- imm  in  16  immediate operand.
- use_imm  in  1  1 = B from imm, 0 = B from rd_sel2.
- op_in  in  3  ALU opcode (000-011 shift/rotate, 100 add, 101 or, 110 xor, 111 and).
- cin_in, inva_in, invb_in, sign_in  in  1 each  ALU controls.
- stall  in  1  downstream hold request.
- flush  in  1  kill staged instruction.
- A, B  out  16 each  registered ALU operands.
- Op  out  3  registered opcode.
- Cin, invA, invB, sign  out  1 each  registered controls.
- out_valid  out  1  staged contents valid.

Function
REQ-002 The register file SHALL hold 8 x 16-bit registers; all 8 are general purpose, with no hardwired zero.
REQ-003 Writes SHALL occur on the rising clk edge when wr_en=1 and rst=0, independent of stall, flush and in_valid.
REQ-004 Reads SHALL be combinational with write-to-read bypass: if wr_en=1 and wr_sel equals a read select in the same cycle, that read returns wr_data, not the stored value.
REQ-005 Selected B source SHALL be imm when use_imm=1, otherwise the bypassed read of rd_sel2.
REQ-006 The staging register SHALL update with the following priority: rst > flush > stall > capture.
REQ-007 flush=1 SHALL clear out_valid to 0 and all data/control outputs to 0 at the next edge, even when stall=1.
REQ-008 stall=1 with flush=0 SHALL hold every output, including out_valid, unchanged. Register-file writes still proceed during stall. Held operands are not refreshed; the upstream hazard unit is responsible for this.
REQ-009 A capture edge (stall=0, flush=0) SHALL load A, B, Op, Cin, invA, invB and sign from the current inputs, and set out_valid=in_valid.
REQ-010 Latency SHALL be exactly one cycle from operand selection to outputs. There is no combinational path from any input to any output.
REQ-011 When in_valid=0 is captured, the data outputs SHALL still load the current inputs. Consumers qualify them with out_valid.

Reset
REQ-012 rst=1 at a clock edge SHALL clear all 8 registers to 0x0000, out_valid to 0, and A, B, Op, Cin, invA, invB and sign to 0.
REQ-013 rst SHALL take precedence over a concurrent wr_en, flush or stall; a write presented in a reset cycle is lost.
REQ-014 Reset asserted mid-operation SHALL discard the staged instruction with no partial update.

Structure
REQ-015 A shared package SHALL hold REG_W=16, NUM_REGS=8, SEL_W=3 and the 3-bit ALU opcode constants (SLL..AND).
REQ-016 The register file SHALL be a sub-module named rf_bypass, containing the storage, the write port and both bypassed read ports. The staging register and B-select mux live in alu_operand_stage.

Verification
REQ-017 Reset, then capture rd_sel1=3, rd_sel2=5, use_imm=0 -> A=0x0000, B=0x0000, out_valid=1.
REQ-018 Write R2=0x1234; next cycle capture rd_sel1=2, op_in=100 -> A=0x1234, Op=100 one cycle later.
REQ-019 Same cycle: wr_en=1, wr_sel=4, wr_data=0xBEEF, rd_sel1=4, rd_sel2=4 -> after the edge A=0xBEEF, B=0xBEEF (bypass).
REQ-020 Capture with use_imm=1, imm=0x00F0 -> B=0x00F0 regardless of rd_sel2 contents.
REQ-021 Staged A=0x1111 with stall=1 for 3 cycles while inputs change -> outputs constant. Then stall=1 and flush=1 together -> out_valid=0, A=0.
REQ-022 Write R7=0xFFFF, then rst=1 with wr_en=1, wr_sel=7, wr_data=0x5555 -> R7 reads 0x0000, all outputs 0.
